// File: rtl/mxu_sequencer.sv
// mxu_sequencer: loads one weight matrix, streams a frame of input vectors through the MXU
// wrapper and returns one result per accepted vector on a valid/ready stream.

`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif

module mxu_sequencer #(
    parameter int M              = 3,
    parameter int K              = 3,
    parameter int max_data_width = 4,
    parameter int CORE_LATENCY   = 3,
    parameter int MAX_BOARD_DSP  = 220
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 test_mode,
    input  logic                                 start,
    input  logic [15:0]                          frame_len,
    input  logic [`LOG_ALLOWED_PRECISIONS-1:0]   data_type_in,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    input  logic [M*K*max_data_width-1:0]        w_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [K*max_data_width-1:0]          s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [M*max_data_width-1:0]          m_data,
    output logic                                 done,
    output logic [`LOG_ALLOWED_PRECISIONS-1:0]   mxu_data_type,
    output logic [M*K*max_data_width-1:0]        mxu_weight,
    output logic [K*max_data_width-1:0]          mxu_input_data,
    output logic                                 mxu_enable,
    output logic                                 mxu_enable_in_ff,
    output logic                                 mxu_enable_chain,
    output logic                                 mxu_enable_out_ff,
    output logic                                 mxu_test_mode,
    input  logic [M*max_data_width-1:0]          mxu_y
);

    // Advancing cycles from wrapper input to wrapper output: skew + core + deskew.
    localparam int L = (K - 1) + CORE_LATENCY + (M - 1);

    if (64 % max_data_width != 0) begin : g_bad_width
        $error("mxu_sequencer: max_data_width must divide 64");
    end
    if (L < 1) begin : g_bad_latency
        $error("mxu_sequencer: total wrapper latency must be at least one cycle");
    end
    if (MAX_BOARD_DSP <= 0) begin : g_bad_dsp
        $error("mxu_sequencer: MAX_BOARD_DSP must be positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   remaining;
    logic [L-1:0]  valid_sr;
    logic          advance;
    logic          accept;
    logic          pipe_enable;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values, independent of the order the always blocks are evaluated in.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = LOAD_W;
            LOAD_W:  if (w_valid) state_next = (remaining != '0) ? RUN : DONE;
            RUN:     if (remaining == '0) state_next = DRAIN;
            DRAIN:   if (valid_sr == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // A result waiting on a stalled consumer freezes the wrapper and the token line together.
    assign advance = !m_valid || m_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        w_ready     = 1'b0;
        s_ready     = 1'b0;
        done        = 1'b0;
        pipe_enable = 1'b0;
        unique case (state)
            LOAD_W: w_ready = 1'b1;
            RUN: begin
                pipe_enable = advance;
                s_ready     = advance && (remaining != '0);
            end
            DRAIN:   pipe_enable = advance;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign accept            = s_valid && s_ready;
    assign mxu_enable        = pipe_enable;
    assign mxu_enable_in_ff  = pipe_enable;
    assign mxu_enable_chain  = pipe_enable;
    assign mxu_enable_out_ff = pipe_enable;
    assign mxu_test_mode     = test_mode;

    // Bubbles present zero data so the wrapper never computes on a stale vector.
    assign mxu_input_data = accept ? s_data : '0;

    assign m_valid = valid_sr[L-1];
    assign m_data  = mxu_y;

    // ------------------------------------------------------------------
    // Frame bookkeeping: length, precision and weights held for the frame
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: mxu_weight is a plain register bank, not a RAM, so it is cleared on reset and
        // the wrapper never sees unknown weights before the first load.
        if (!reset) begin
            remaining     <= '0;
            mxu_data_type <= '0;
            mxu_weight    <= '0;
        end else begin
            if (state == IDLE && start) begin
                remaining     <= frame_len;
                mxu_data_type <= data_type_in;
            end else if (accept) begin
                remaining <= remaining - 16'd1;
            end
            if (state == LOAD_W && w_valid) begin
                mxu_weight <= w_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Token line: mirrors the wrapper pipeline, one bit per in-flight slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_sr <= '0;
        end else if (pipe_enable) begin
            valid_sr <= (valid_sr << 1) | L'(accept);
        end
    end

    a_mvalid_in_frame: assert property (@(posedge clk) disable iff (!reset)
        m_valid |-> (state == RUN || state == DRAIN));

    a_stall_holds: assert property (@(posedge clk) disable iff (!reset)
        (m_valid && !m_ready) |=> m_valid);

    a_one_ready: assert property (@(posedge clk) disable iff (!reset)
        !(w_ready && s_ready));

endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer with a behavioural stand-in for the MXU wrapper
// (L-stage enabled pipeline computing W*x).

`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif

module tb_mxu_sequencer;

    localparam int M    = 3;
    localparam int K    = 3;
    localparam int DW   = 4;
    localparam int CL   = 3;
    localparam int L    = (K - 1) + CL + (M - 1);
    localparam int DT_W = `LOG_ALLOWED_PRECISIONS;
    // Diagonal ones at (m*K+k)*DW for m == k: bits 0, 16 and 32.
    localparam logic [M*K*DW-1:0] W_IDENT = 36'h1_0001_0001;
    localparam logic [M*K*DW-1:0] W_OTHER = 36'h1_2345_6789;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 test_mode = 1'b0;
    logic                 start = 1'b0;
    logic [15:0]          frame_len = '0;
    logic [DT_W-1:0]      data_type_in = '0;
    logic                 w_valid = 1'b0;
    logic                 w_ready;
    logic [M*K*DW-1:0]    w_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [K*DW-1:0]      s_data = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [M*DW-1:0]      m_data;
    logic                 done;
    logic [DT_W-1:0]      mxu_data_type;
    logic [M*K*DW-1:0]    mxu_weight;
    logic [K*DW-1:0]      mxu_input_data;
    logic                 mxu_enable;
    logic                 mxu_enable_in_ff;
    logic                 mxu_enable_chain;
    logic                 mxu_enable_out_ff;
    logic                 mxu_test_mode;
    logic [M*DW-1:0]      mxu_y;

    mxu_sequencer #(
        .M              (M),
        .K              (K),
        .max_data_width (DW),
        .CORE_LATENCY   (CL),
        .MAX_BOARD_DSP  (220)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .test_mode         (test_mode),
        .start             (start),
        .frame_len         (frame_len),
        .data_type_in      (data_type_in),
        .w_valid           (w_valid),
        .w_ready           (w_ready),
        .w_data            (w_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .done              (done),
        .mxu_data_type     (mxu_data_type),
        .mxu_weight        (mxu_weight),
        .mxu_input_data    (mxu_input_data),
        .mxu_enable        (mxu_enable),
        .mxu_enable_in_ff  (mxu_enable_in_ff),
        .mxu_enable_chain  (mxu_enable_chain),
        .mxu_enable_out_ff (mxu_enable_out_ff),
        .mxu_test_mode     (mxu_test_mode),
        .mxu_y             (mxu_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- wrapper stand-in ----------------
    function automatic logic [M*DW-1:0] matvec(input logic [M*K*DW-1:0] w, input logic [K*DW-1:0] x);
        logic [M*DW-1:0] y;
        logic [7:0]      acc;
        y = '0;
        for (int m = 0; m < M; m++) begin
            acc = '0;
            for (int k = 0; k < K; k++) acc = acc + 8'(w[(m*K+k)*DW +: DW] * x[k*DW +: DW]);
            y[m*DW +: DW] = acc[DW-1:0];
        end
        return y;
    endfunction

    logic [M*DW-1:0] pipe [L];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else if (mxu_enable) begin
            pipe[0] <= matvec(mxu_weight, mxu_input_data);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mxu_y = pipe[L-1];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int              acc_q[$];
    int              out_cyc_q[$];
    logic [M*DW-1:0] out_dat_q[$];
    int              done_q[$];
    int              w_hs_cyc = -1;
    int              w_raise_cyc = -1;
    logic            stall_chk = 1'b0;
    logic [M*DW-1:0] stall_exp = '0;
    int              stall_cycles = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (s_valid && s_ready) acc_q.push_back(cyc);
            if (m_valid && m_ready) begin
                out_cyc_q.push_back(cyc);
                out_dat_q.push_back(m_data);
            end
            if (w_valid && w_ready) w_hs_cyc = cyc;
            if (done) done_q.push_back(cyc);
            check("in_data", 64'(mxu_input_data), 64'((s_valid && s_ready) ? s_data : '0));
            if (stall_chk && m_valid && !m_ready) begin
                stall_cycles++;
                check("stall_s_ready", 64'(s_ready), 64'd0);
                check("stall_enables", 64'({mxu_enable, mxu_enable_in_ff, mxu_enable_chain, mxu_enable_out_ff}), 64'd0);
                check("stall_m_data", 64'(m_data), 64'(stall_exp));
            end
        end
    end

    // Holds m_ready low for stall_len cycles starting at the first m_valid it sees.
    int stall_len = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_len > 0 && m_valid) begin
                m_ready = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
                m_ready = 1'b1;
                stall_len = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [K*DW-1:0] vecs [4];
    int              exp_off [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        out_cyc_q.delete();
        out_dat_q.delete();
        done_q.delete();
        w_hs_cyc = -1;
        stall_cycles = 0;
    endtask

    task automatic launch(input int n, input logic [M*K*DW-1:0] w);
        start = 1'b1;
        frame_len = 16'(n);
        data_type_in = DT_W'(2);
        w_valid = 1'b1;
        w_data = w;
        w_raise_cyc = cyc;
        tick();
        start = 1'b0;
        frame_len = '0;
        data_type_in = '0;
        tick();
        w_valid = 1'b0;
        w_data = '0;
    endtask

    // pat[i] is s_valid for slot i; a slot holds until accepted, slots past 4 are valid.
    task automatic stream(input int n, input logic [4:0] pat);
        int   sent;
        int   slot;
        logic acc;
        sent = 0;
        slot = 0;
        for (int b = 0; b < 64 && sent < n; b++) begin
            s_valid = (slot < 5) ? pat[slot] : 1'b1;
            s_data = s_valid ? vecs[sent] : 12'hFFF;
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) check("en_on_accept", 64'({mxu_enable, mxu_enable_in_ff, mxu_enable_chain, mxu_enable_out_ff}), 64'hF);
            tick();
            if (acc) sent++;
            if (acc || !s_valid) slot++;
        end
        s_valid = 1'b0;
        s_data = '0;
        check("stream_sent", 64'(sent), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && done_q.size() == 0; i++) tick();
        check({tag, "_done_seen"}, 64'(done_q.size()), 64'd1);
        repeat (2) tick();
    endtask

    // With identity weights every result equals its input vector.
    task automatic check_frame(input string tag, input int n, input int lat);
        check({tag, "_acc_cnt"}, 64'(acc_q.size()), 64'(n));
        check({tag, "_out_cnt"}, 64'(out_cyc_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i > 0 && i < acc_q.size())
                check({tag, "_acc_slot"}, 64'(acc_q[i] - acc_q[0]), 64'(exp_off[i]));
            if (i < acc_q.size() && i < out_cyc_q.size()) begin
                check({tag, "_latency"}, 64'(out_cyc_q[i] - acc_q[i]), 64'(lat));
                check({tag, "_data"}, 64'(out_dat_q[i]), 64'(vecs[i]));
            end
        end
        if (n > 0 && out_cyc_q.size() == n && done_q.size() == 1)
            check({tag, "_done_after_last"}, 64'(done_q[0] > out_cyc_q[n-1]), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = 12'h321;   // {1,2,3}
        vecs[1] = 12'h654;   // {4,5,6}
        vecs[2] = 12'h987;   // {7,8,9}
        vecs[3] = 12'h222;   // {2,2,2}

        // Reset, then idle with junk on s_data.
        s_data = 12'hABC;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ctrl", 64'({w_ready, s_ready, m_valid, done, mxu_enable, mxu_enable_in_ff,
                                     mxu_enable_chain, mxu_enable_out_ff, mxu_test_mode}), 64'd0);
            check("idle_data", 64'({m_data, mxu_input_data, mxu_data_type}), 64'd0);
        end
        check("idle_weight", 64'(mxu_weight), 64'd0);
        tick();
        s_data = '0;

        // Basic frame, no backpressure.
        test_mode = 1'b1;
        clear_logs();
        launch(4, W_IDENT);
        check("run_data_type", 64'(mxu_data_type), 64'd2);
        check("run_weight", 64'(mxu_weight), 64'(W_IDENT));
        check("run_test_mode", 64'(mxu_test_mode), 64'd1);
        stream(4, 5'b11111);
        wait_done("basic");
        exp_off = '{0, 1, 2, 3};
        check_frame("basic", 4, L);
        test_mode = 1'b0;

        // Same frame, consumer stalls five cycles at the first result.
        clear_logs();
        stall_len = 5;
        stall_chk = 1'b1;
        stall_exp = vecs[0];
        launch(4, W_IDENT);
        stream(4, 5'b11111);
        wait_done("stall");
        stall_chk = 1'b0;
        check("stall_cycles", 64'(stall_cycles), 64'd5);
        check_frame("stall", 4, L + 5);

        // Gaps in s_valid: 1,0,0,1,1.
        clear_logs();
        launch(3, W_IDENT);
        stream(3, 5'b11001);
        wait_done("gaps");
        exp_off = '{0, 3, 4, 0};
        check_frame("gaps", 3, L);

        // Empty frame: weights still taken, done two cycles after w_valid rises.
        clear_logs();
        launch(0, W_OTHER);
        wait_done("empty");
        check("empty_weight", 64'(mxu_weight), 64'(W_OTHER));
        check("empty_hs_to_done", 64'(done_q.size() > 0 ? done_q[0] - w_hs_cyc : -1), 64'd1);
        check("empty_raise_to_done", 64'(done_q.size() > 0 ? done_q[0] - w_raise_cyc : -1), 64'd2);
        check("empty_no_out", 64'(out_cyc_q.size()), 64'd0);

        // Reset after two accepted vectors.
        clear_logs();
        launch(4, W_IDENT);
        s_valid = 1'b1;
        for (int b = 0; b < 20 && acc_q.size() < 2; b++) begin
            s_data = vecs[acc_q.size()];
            tick();
        end
        reset = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        tick();
        reset = 1'b1;
        repeat (15) tick();
        @(negedge clk);
        check("rst_acc_cnt", 64'(acc_q.size()), 64'd2);
        check("rst_no_out", 64'(out_cyc_q.size()), 64'd0);
        check("rst_no_done", 64'(done_q.size()), 64'd0);
        check("rst_idle_ctrl", 64'({w_ready, s_ready, m_valid, mxu_enable}), 64'd0);
        tick();

        // Clean frame after the reset.
        clear_logs();
        launch(4, W_IDENT);
        stream(4, 5'b11111);
        wait_done("post_rst");
        exp_off = '{0, 1, 2, 3};
        check_frame("post_rst", 4, L);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
